lawn_cursor_ctrl: RTL and testbench
===================================

// Module: lawn_cursor_ctrl
// PURPOSE
//  Upstream of the VGA pixel/colour stage. Debounces the five board buttons and runs the
//  player's plant-box / lawn-cursor selection FSM. Owns the 5x5 lawn occupancy map.
//  Outputs are registered; the colour stage consumes them to highlight the box/cell and draw plants.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before a button change is accepted (>=2)
//  NUM_PLANT_TYPES  2       plant boxes in grey zone; valid plantType 0..NUM_PLANT_TYPES-1 (<=4)
// PORTS
//  clk                  in   1   system clock
//  reset                in   1   synchronous, active-high reset
//  upButton             in   1   raw async button, active-high
//  downButton           in   1   raw async button
//  leftButton           in   1   raw async button
//  rightButton          in   1   raw async button
//  selectButton         in   1   raw async button
//  lawnClear            in   1   1-cycle pulse from game FSM (new level): clear occupancy map
//  isSelectingPlantBox  out  1   1 = FSM in SEL_BOX, 0 = SEL_LAWN
//  plantType            out  2   currently highlighted plant box
//  cursorRow            out  3   lawn cursor row 0..4 (0 = top)
//  cursorCol            out  3   lawn cursor column 0..4 (0 = left)
//  plantGrid            out  25  occupancy, bit index row*5+col
//  plantPlaced          out  1   1-cycle pulse on successful placement
//  placedType           out  2   plantType of last placement, valid with plantPlaced
// BEHAVIOUR
//  Reset: state SEL_BOX, isSelectingPlantBox=1, plantType=0, cursorRow=0, cursorCol=0,
//   plantGrid=0, plantPlaced=0, placedType=0, all debounce counters/stable levels 0.
//  Debounce, per button: 2-FF synchroniser -> counter of consecutive cycles sync!=stable;
//   counter clears on any cycle sync==stable; at DEBOUNCE_CYCLES stable toggles, counter clears.
//   Press event = 1-cycle pulse on stable 0->1 only; release produces nothing.
//   Latency: raw rise held steady -> press pulse high exactly DEBOUNCE_CYCLES+3 edges later.
//   Glitch shorter than DEBOUNCE_CYCLES cycles -> no event. Held button -> exactly one event.
//  Arbitration: >1 press pulse in same cycle -> only highest taken, rest dropped:
//   select > up > down > left > right.
//  FSM SEL_BOX:
//   left: plantType-1, saturate at 0. right: plantType+1, saturate at NUM_PLANT_TYPES-1.
//   select: -> SEL_LAWN; cursor keeps its last position. up/down: ignored.
//  FSM SEL_LAWN:
//   up/down/left/right move cursor by 1, saturating at 0 and 4 (no wrap).
//   up while cursorRow==0: -> SEL_BOX, cursor unchanged.
//   select on free cell: set bit, plantPlaced=1 next cycle, placedType=plantType, -> SEL_BOX.
//   select on occupied cell: no change, no pulse, stay SEL_LAWN.
//  lawnClear: plantGrid<=0 on next edge; state/cursor/plantType unaffected. If it coincides
//   with a placement, the clear wins (grid 0, but plantPlaced still pulses).
//  Reset mid-debounce or mid-move: everything returns to reset values next edge; a button
//   held through reset deasserting generates one fresh press after full debounce latency.
//  All outputs change only on clk rising edge; no combinational input->output paths.
// TESTING  (DEBOUNCE_CYCLES=4, NUM_PLANT_TYPES=2)
//  reset, hold rightButton 20 cycles -> single event, plantType 0->1 at edge 7; stays 1.
//  3-cycle glitch on leftButton -> no change; right x2 at plantType=1 -> stays 1 (saturate).
//  select, then down x6, right x6 -> SEL_LAWN, cursorRow=4, cursorCol=4 (saturate, no wrap).
//  select at (4,4) -> plantGrid[24]=1, one plantPlaced pulse, placedType=1, isSelectingPlantBox=1;
//   re-enter, select at (4,4) again -> no pulse, grid unchanged, stays SEL_LAWN.
//  up+select debounced on same cycle in SEL_LAWN, row 0, free cell -> placement only (select wins).
//  lawnClear pulse with 3 bits set -> plantGrid=0 next edge; reset while debouncing -> all reset values.

Source files
------------

// File: rtl/lawn_cursor_ctrl.sv
// Player input front end: debounces the five board buttons, arbitrates presses and runs the
// plant-box / lawn-cursor selection FSM that owns the 5x5 lawn occupancy map.
module lawn_cursor_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_PLANT_TYPES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upButton,
    input  logic        downButton,
    input  logic        leftButton,
    input  logic        rightButton,
    input  logic        selectButton,
    input  logic        lawnClear,
    output logic        isSelectingPlantBox,
    output logic [1:0]  plantType,
    output logic [2:0]  cursorRow,
    output logic [2:0]  cursorCol,
    output logic [24:0] plantGrid,
    output logic        plantPlaced,
    output logic [1:0]  placedType
);

    localparam int              NUM_BTN  = 5;
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]      TYPE_MAX = 2'(NUM_PLANT_TYPES - 1);
    localparam logic [2:0]      EDGE_MAX = 3'd4;

    // Bit positions inside the packed button vectors.
    localparam int B_SELECT = 0;
    localparam int B_UP     = 1;
    localparam int B_DOWN   = 2;
    localparam int B_LEFT   = 3;
    localparam int B_RIGHT  = 4;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_SELECT,
        CMD_UP,
        CMD_DOWN,
        CMD_LEFT,
        CMD_RIGHT
    } cmd_e;

    typedef enum logic {
        SEL_BOX,
        SEL_LAWN
    } state_e;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync_a;
    logic [NUM_BTN-1:0] sync_b;
    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] press;
    logic [CW-1:0]      cnt [NUM_BTN];

    cmd_e       cmd;
    state_e     state;
    logic [4:0] cell_idx;
    logic       cell_busy;

    assign raw = {rightButton, leftButton, downButton, upButton, selectButton};

    // Each button: 2-FF synchroniser, then a run-length counter of cycles where the
    // synchronised level disagrees with the accepted level. Only a 0->1 acceptance emits a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
            stable <= '0;
            press  <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is reset
            // with everything else; a stale count would shorten the first debounce after reset.
            for (int b = 0; b < NUM_BTN; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep sync_b sampling the old sync_a, which is
            // what makes this a two-stage synchroniser rather than a single wire.
            sync_a <= raw;
            sync_b <= sync_a;
            press  <= '0;
            for (int b = 0; b < NUM_BTN; b++) begin
                if (sync_b[b] == stable[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_LAST) begin
                    stable[b] <= ~stable[b];
                    cnt[b]    <= '0;
                    press[b]  <= ~stable[b];
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end

    // Fixed priority: select > up > down > left > right; losers are dropped, not queued.
    always_comb begin
        // NOTE: the default assignment first guarantees cmd is written on every path,
        // so no latch is inferred.
        cmd = CMD_NONE;
        if (press[B_SELECT]) begin
            cmd = CMD_SELECT;
        end else if (press[B_UP]) begin
            cmd = CMD_UP;
        end else if (press[B_DOWN]) begin
            cmd = CMD_DOWN;
        end else if (press[B_LEFT]) begin
            cmd = CMD_LEFT;
        end else if (press[B_RIGHT]) begin
            cmd = CMD_RIGHT;
        end
    end

    assign cell_idx  = 5'(cursorRow) * 5'd5 + 5'(cursorCol);
    assign cell_busy = plantGrid[cell_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= SEL_BOX;
            isSelectingPlantBox <= 1'b1;
            plantType           <= '0;
            cursorRow           <= '0;
            cursorCol           <= '0;
            plantGrid           <= '0;
            plantPlaced         <= 1'b0;
            placedType          <= '0;
        end else begin
            plantPlaced <= 1'b0;
            unique case (state)
                SEL_BOX: begin
                    case (cmd)
                        CMD_LEFT: begin
                            if (plantType != 2'd0) plantType <= plantType - 1'b1;
                        end
                        CMD_RIGHT: begin
                            if (plantType < TYPE_MAX) plantType <= plantType + 1'b1;
                        end
                        CMD_SELECT: begin
                            state               <= SEL_LAWN;
                            isSelectingPlantBox <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                SEL_LAWN: begin
                    case (cmd)
                        CMD_UP: begin
                            if (cursorRow == 3'd0) begin
                                state               <= SEL_BOX;
                                isSelectingPlantBox <= 1'b1;
                            end else begin
                                cursorRow <= cursorRow - 1'b1;
                            end
                        end
                        CMD_DOWN: begin
                            if (cursorRow < EDGE_MAX) cursorRow <= cursorRow + 1'b1;
                        end
                        CMD_LEFT: begin
                            if (cursorCol != 3'd0) cursorCol <= cursorCol - 1'b1;
                        end
                        CMD_RIGHT: begin
                            if (cursorCol < EDGE_MAX) cursorCol <= cursorCol + 1'b1;
                        end
                        CMD_SELECT: begin
                            if (!cell_busy) begin
                                plantGrid[cell_idx] <= 1'b1;
                                plantPlaced         <= 1'b1;
                                placedType          <= plantType;
                                state               <= SEL_BOX;
                                isSelectingPlantBox <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
            // Placed last so a coinciding clear overrides the placement bit; the pulse still fires.
            if (lawnClear) plantGrid <= '0;
        end
    end

endmodule

// File: tb/tb_lawn_cursor_ctrl.sv
// Bench for lawn_cursor_ctrl: directed scenarios plus randomized button traffic, every cycle
// compared against a behavioural model of the debounce windows and the cursor rules.
module tb_lawn_cursor_ctrl;

    localparam int N  = 4;
    localparam int NT = 2;

    localparam int S  = 0;  // select
    localparam int U  = 1;  // up
    localparam int D  = 2;  // down
    localparam int L  = 3;  // left
    localparam int R  = 4;  // right

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  btn;
    logic        lawnClear;
    logic        isSelectingPlantBox;
    logic [1:0]  plantType;
    logic [2:0]  cursorRow;
    logic [2:0]  cursorCol;
    logic [24:0] plantGrid;
    logic        plantPlaced;
    logic [1:0]  placedType;

    int n_checks = 0;
    int n_errors = 0;
    int place_cnt = 0;
    int p0;

    lawn_cursor_ctrl #(
        .DEBOUNCE_CYCLES (N),
        .NUM_PLANT_TYPES (NT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .upButton            (btn[U]),
        .downButton          (btn[D]),
        .leftButton          (btn[L]),
        .rightButton         (btn[R]),
        .selectButton        (btn[S]),
        .lawnClear           (lawnClear),
        .isSelectingPlantBox (isSelectingPlantBox),
        .plantType           (plantType),
        .cursorRow           (cursorRow),
        .cursorCol           (cursorCol),
        .plantGrid           (plantGrid),
        .plantPlaced         (plantPlaced),
        .placedType          (placedType)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a button's accepted level flips once its last N raw samples (taken since
    // the previous flip) all disagree with it; the resulting action lands 3 edges after the
    // N-th sample (two synchroniser stages plus the registered press).
    bit          model_valid = 1'b0;
    logic [4:0]  pipe [$];
    logic [31:0] hist [5];
    int          since [5];
    logic [4:0]  lvl;
    bit          m_box;
    int          m_type, m_row, m_col;
    logic [24:0] m_grid;
    bit          m_placed;
    int          m_ptype;

    always @(posedge clk) begin : ref_model
        logic [4:0] pv;
        logic [4:0] newp;
        bit         differ;
        if (reset) begin
            model_valid = 1'b1;
            pipe = {5'd0, 5'd0, 5'd0};
            for (int b = 0; b < 5; b++) begin
                hist[b]  = '0;
                since[b] = 0;
            end
            lvl = '0;
            m_box = 1'b1; m_type = 0; m_row = 0; m_col = 0;
            m_grid = '0; m_placed = 1'b0; m_ptype = 0;
        end else begin
            pv = pipe.pop_front();
            m_placed = 1'b0;
            if (m_box) begin
                if (pv[S]) m_box = 1'b0;
                else if (pv[U] || pv[D]) m_box = 1'b1;
                else if (pv[L]) m_type = (m_type > 0) ? m_type - 1 : 0;
                else if (pv[R]) m_type = (m_type < NT - 1) ? m_type + 1 : NT - 1;
            end else begin
                if (pv[S]) begin
                    if (!m_grid[m_row * 5 + m_col]) begin
                        m_grid[m_row * 5 + m_col] = 1'b1;
                        m_placed = 1'b1;
                        m_ptype  = m_type;
                        m_box    = 1'b1;
                    end
                end else if (pv[U]) begin
                    if (m_row == 0) m_box = 1'b1;
                    else m_row = m_row - 1;
                end else if (pv[D]) m_row = (m_row < 4) ? m_row + 1 : 4;
                else if (pv[L]) m_col = (m_col > 0) ? m_col - 1 : 0;
                else if (pv[R]) m_col = (m_col < 4) ? m_col + 1 : 4;
            end
            if (lawnClear) m_grid = '0;

            newp = '0;
            for (int b = 0; b < 5; b++) begin
                hist[b]  = {hist[b][30:0], btn[b]};
                since[b] = since[b] + 1;
                differ = 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (hist[b][k] == lvl[b]) differ = 1'b0;
                end
                if (since[b] >= N && differ) begin
                    lvl[b]   = ~lvl[b];
                    since[b] = 0;
                    if (lvl[b]) newp[b] = 1'b1;
                end
            end
            pipe.push_back(newp);
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("m_sel",    32'(isSelectingPlantBox), 32'(m_box));
            check("m_type",   32'(plantType),           32'(m_type));
            check("m_row",    32'(cursorRow),           32'(m_row));
            check("m_col",    32'(cursorCol),           32'(m_col));
            check("m_grid",   32'(plantGrid),           32'(m_grid));
            check("m_placed", 32'(plantPlaced),         32'(m_placed));
            check("m_ptype",  32'(placedType),          32'(m_ptype));
        end
    end

    task automatic tick();
        @(negedge clk);
        if (plantPlaced) place_cnt++;
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        repeat (8) tick();
        btn[b] = 1'b0;
        repeat (8) tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sel"},    32'(isSelectingPlantBox), 32'd1);
        check({tag, "_type"},   32'(plantType),           32'd0);
        check({tag, "_row"},    32'(cursorRow),           32'd0);
        check({tag, "_col"},    32'(cursorCol),           32'd0);
        check({tag, "_grid"},   32'(plantGrid),           32'd0);
        check({tag, "_placed"}, 32'(plantPlaced),         32'd0);
        check({tag, "_ptype"},  32'(placedType),          32'd0);
    endtask

    initial begin
        reset = 1'b1;
        btn = '0;
        lawnClear = 1'b0;
        repeat (3) tick();
        check_reset_state("rst");

        // Held right: exactly one event, landing on the 7th edge.
        reset = 1'b0;
        btn[R] = 1'b1;
        repeat (6) tick();
        check("deb_edge6", 32'(plantType), 32'd0);
        tick();
        check("deb_edge7", 32'(plantType), 32'd1);
        repeat (13) tick();
        btn[R] = 1'b0;
        repeat (10) tick();
        check("held_once", 32'(plantType), 32'd1);

        btn[L] = 1'b1;
        repeat (3) tick();
        btn[L] = 1'b0;
        repeat (10) tick();
        check("glitch", 32'(plantType), 32'd1);

        press(R);
        press(R);
        check("type_sat_hi", 32'(plantType), 32'd1);

        press(S);
        check("to_lawn_sel", 32'(isSelectingPlantBox), 32'd0);
        check("to_lawn_row", 32'(cursorRow), 32'd0);
        repeat (6) press(D);
        repeat (6) press(R);
        check("sat_row", 32'(cursorRow), 32'd4);
        check("sat_col", 32'(cursorCol), 32'd4);
        check("sat_sel", 32'(isSelectingPlantBox), 32'd0);

        p0 = place_cnt;
        press(S);
        check("place_grid",  32'(plantGrid), 32'h100_0000);
        check("place_pulse", 32'(place_cnt - p0), 32'd1);
        check("place_type",  32'(placedType), 32'd1);
        check("place_sel",   32'(isSelectingPlantBox), 32'd1);

        press(S);
        p0 = place_cnt;
        press(S);
        check("busy_pulse", 32'(place_cnt - p0), 32'd0);
        check("busy_grid",  32'(plantGrid), 32'h100_0000);
        check("busy_sel",   32'(isSelectingPlantBox), 32'd0);

        repeat (4) press(U);
        check("up_row0", 32'(cursorRow), 32'd0);
        check("up_sel",  32'(isSelectingPlantBox), 32'd0);
        p0 = place_cnt;
        btn[U] = 1'b1;
        btn[S] = 1'b1;
        repeat (8) tick();
        btn = '0;
        repeat (8) tick();
        check("arb_grid",  32'(plantGrid), 32'h100_0010);
        check("arb_pulse", 32'(place_cnt - p0), 32'd1);
        check("arb_sel",   32'(isSelectingPlantBox), 32'd1);
        check("arb_row",   32'(cursorRow), 32'd0);

        press(S);
        press(L);
        press(S);
        check("three_bits", 32'(plantGrid), 32'h100_0018);
        lawnClear = 1'b1;
        tick();
        lawnClear = 1'b0;
        check("clear_grid", 32'(plantGrid), 32'd0);
        check("clear_col",  32'(cursorCol), 32'd3);
        check("clear_sel",  32'(isSelectingPlantBox), 32'd1);

        press(L);
        press(L);
        check("type_sat_lo", 32'(plantType), 32'd0);

        // Reset while right is mid-debounce and still held afterwards.
        btn[R] = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_state("mid_rst");
        reset = 1'b0;
        repeat (6) tick();
        check("fresh_edge6", 32'(plantType), 32'd0);
        tick();
        check("fresh_edge7", 32'(plantType), 32'd1);
        btn = '0;
        repeat (10) tick();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) btn = 5'($urandom_range(0, 31));
            else btn = 5'(1 << $urandom_range(0, 4));
            for (int h = 0; h < int'($urandom_range(1, 10)); h++) begin
                lawnClear = ($urandom_range(0, 19) == 0);
                reset     = ($urandom_range(0, 199) == 0);
                tick();
            end
            lawnClear = 1'b0;
            reset = 1'b0;
            btn = '0;
            repeat ($urandom_range(0, 9)) tick();
        end
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
